// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 datapath: grants one requester for a bounded
// burst, steers its word into a registered valid/ready output stage, and pulses ack.
module mux_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [3:0]       ack,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    state_t           state_reg;
    logic [1:0]       ptr_reg;
    logic [1:0]       sel_reg;
    logic [3:0]       grant_reg;
    logic [3:0]       count_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] words [4];
    logic [1:0]       cand [4];
    logic [3:0]       hit;
    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             accept;
    logic             last_beat;
    logic             release_now;

    assign words[0] = in1;
    assign words[1] = in2;
    assign words[2] = in3;
    assign words[3] = in4;

    // cand[k] is the requester at priority rank k, counted from the pointer
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rank
            assign cand[gi] = ptr_reg + 2'(gi);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_reg;
        for (int k = 0; k < 4; k++) begin
            if (!pick_valid && hit[k]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[k];
            end
        end
    end

    assign accept      = (state_reg == GRANT) && req[sel_reg] && (count_reg < BURST)
                         && (!out_valid_reg || out_ready);
    assign last_beat   = accept && ((count_reg + 4'd1) == BURST);
    assign release_now = (state_reg == GRANT) && (!req[sel_reg] || last_beat);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_ack
            assign ack[gi] = accept && (sel_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= 2'd0;
            sel_reg       <= 2'd0;
            grant_reg     <= 4'd0;
            count_reg     <= 4'd0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg <= GRANT;
                        sel_reg   <= pick_idx;
                        grant_reg <= 4'b0001 << pick_idx;
                        count_reg <= 4'd0;
                    end
                end
                GRANT: begin
                    if (accept)
                        count_reg <= count_reg + 4'd1;
                    // Pointer advances even on a zero-beat release so a flapping owner cannot starve others
                    if (release_now) begin
                        state_reg <= IDLE;
                        grant_reg <= 4'd0;
                        ptr_reg   <= sel_reg + 2'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (accept) begin
                out_data_reg  <= words[sel_reg];
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign grant     = grant_reg;
    assign sel       = sel_reg;
    assign busy      = (state_reg == GRANT);
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: constant vector table, directed corner
// sequences and randomized traffic, all compared against an integer-level model.
module tb_mux_rr_arbiter;

    localparam int W  = 16;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = 4'd0;
    logic [W-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic [3:0]   ack;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         busy;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;

    mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .ack(ack), .grant(grant), .sel(sel), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner index, priority pointer, beats in this grant, output word
    bit           m_busy;
    int           m_owner;
    int           m_ptr;
    int           m_count;
    bit           m_valid;
    logic [W-1:0] m_data;

    function automatic logic [W-1:0] word_of(int i);
        case (i)
            0:       return in1;
            1:       return in2;
            2:       return in3;
            default: return in4;
        endcase
    endfunction

    function automatic bit m_accept();
        return m_busy && req[m_owner] && (m_count < MB) && (!m_valid || out_ready);
    endfunction

    function automatic logic [3:0] m_ack();
        return m_accept() ? 4'(1 << m_owner) : 4'd0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_count = 0; m_valid = 0; m_data = '0;
    endtask

    task automatic model_step();
        bit acc;
        acc = m_accept();
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && req[(m_ptr + k) % 4]) begin
                    m_busy = 1; m_owner = (m_ptr + k) % 4; m_count = 0;
                end
            end
            if (m_valid && out_ready) m_valid = 0;
        end else begin
            if (acc) begin
                m_data = word_of(m_owner); m_valid = 1; m_count++;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (!req[m_owner] || (acc && m_count == MB)) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % 4;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        check("grant", 32'(grant), m_busy ? 32'(1 << m_owner) : 32'd0);
        check("sel", 32'(sel), 32'(m_owner));
        check("busy", 32'(busy), 32'(m_busy));
        check("ack", 32'(ack), 32'(m_ack()));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
    endtask

    // Drive inputs (at posedge+1), then compare at the falling edge
    task automatic apply(input logic [3:0] r, input logic rdy);
        req = r; out_ready = rdy;
        @(negedge clk);
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin apply(4'd0, 1'b1); tick(); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] r;
        logic [3:0] e_grant;
        logic [1:0] e_sel;
        logic [3:0] e_ack;
        logic       e_valid;
        logic [W-1:0] e_data;
    } vec_t;

    vec_t tbl [8];
    logic [3:0] order [$];
    logic [3:0] prev_grant;
    int ack_cnt [4];
    int acks;

    initial begin
        tbl[0] = '{4'b0100, 4'b0000, 2'b00, 4'b0000, 1'b0, 16'h0000};
        tbl[1] = '{4'b0100, 4'b0100, 2'b10, 4'b0100, 1'b0, 16'h0000};
        tbl[2] = '{4'b0100, 4'b0100, 2'b10, 4'b0100, 1'b1, 16'hA5A5};
        tbl[3] = '{4'b0100, 4'b0100, 2'b10, 4'b0100, 1'b1, 16'hA5A5};
        tbl[4] = '{4'b0100, 4'b0100, 2'b10, 4'b0100, 1'b1, 16'hA5A5};
        tbl[5] = '{4'b0100, 4'b0000, 2'b10, 4'b0000, 1'b1, 16'hA5A5};
        tbl[6] = '{4'b0100, 4'b0100, 2'b10, 4'b0100, 1'b0, 16'hA5A5};
        tbl[7] = '{4'b0100, 4'b0100, 2'b10, 4'b0100, 1'b1, 16'hA5A5};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // Single requester, full bursts, re-grant after one bubble
        in3 = 16'hA5A5;
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].r, 1'b1);
            check("tbl_grant", 32'(grant), 32'(tbl[i].e_grant));
            check("tbl_sel", 32'(sel), 32'(tbl[i].e_sel));
            check("tbl_ack", 32'(ack), 32'(tbl[i].e_ack));
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                check("tbl_data", 32'(out_data), 32'(tbl[i].e_data));
            if (i < 7) tick();
        end

        // Asynchronous reset while granted with a pending word
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(4'b0001, 1'b1); tick();
        apply(4'b0001, 1'b1);
        check("post_rst_grant", 32'(grant), 32'b0001);
        check("post_rst_sel", 32'(sel), 32'd0);
        tick();
        idle(3);

        // All requesters, bursts of two, expect order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        prev_grant = 4'd0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            logic [3:0] r;
            logic [3:0] e;
            for (int i = 0; i < 4; i++) r[i] = (ack_cnt[i] < 2);
            apply(r, 1'b1);
            e = m_ack();
            if (grant != 4'd0 && prev_grant == 4'd0) order.push_back(grant);
            prev_grant = grant;
            for (int i = 0; i < 4; i++) begin
                if (!r[i]) ack_cnt[i] = 0;
                else if (e[i]) ack_cnt[i]++;
            end
            tick();
        end
        check("order_len", 32'(order.size()), 32'd5);
        if (order.size() == 5) begin
            check("order0", 32'(order[0]), 32'b0001);
            check("order1", 32'(order[1]), 32'b0010);
            check("order2", 32'(order[2]), 32'b0100);
            check("order3", 32'(order[3]), 32'b1000);
            check("order4", 32'(order[4]), 32'b0001);
        end
        idle(4);

        // Backpressure on requester 1
        in2 = 16'h1111;
        acks = 0;
        apply(4'b0010, 1'b1); tick();
        apply(4'b0010, 1'b1);
        if (ack[1]) acks++;
        tick();
        in2 = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            apply(4'b0010, 1'b0);
            if (ack[1]) acks++;
            check("bp_data", 32'(out_data), 32'h1111);
            check("bp_valid", 32'(out_valid), 32'd1);
            tick();
        end
        check("bp_acks", 32'(acks), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply(4'b0010, 1'b1);
            check("bp_resume_ack", 32'(ack), 32'b0010);
            tick();
        end
        idle(3);

        // Fairness: requester 0 drops before any beat, pointer still advances
        do_reset();
        apply(4'b0011, 1'b1); tick();
        apply(4'b0010, 1'b1);
        check("fair_no_ack", 32'(ack), 32'd0);
        tick();
        apply(4'b0010, 1'b1);
        check("fair_idle", 32'(grant), 32'd0);
        tick();
        apply(4'b0010, 1'b1);
        check("fair_grant1", 32'(grant), 32'b0010);
        check("fair_ack1", 32'(ack), 32'b0010);
        tick();
        apply(4'b0010, 1'b1); tick();
        apply(4'b0000, 1'b1); tick();
        apply(4'b0110, 1'b1); tick();
        apply(4'b0110, 1'b1);
        check("fair_ptr2", 32'(grant), 32'b0100);
        tick();
        idle(3);

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            logic [3:0] r;
            if ($urandom_range(0, 99) == 0) do_reset();
            for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) < 7);
            in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom); in4 = W'($urandom);
            apply(r, ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
